hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS-like core. It takes decoded control flags from ID and EX, plus the data-memory ready handshake, and drives every pipeline-register enable, every flush and the PC source select. It enforces load-use stalls, memory-wait freezes, ID-stage jump redirects and EX-stage branch/JR redirects. It also keeps saturating stall and flush statistics and runs a memory-wait watchdog.

---
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-controller signals: decoded ID/EX/MEM flags in,
// pipeline enables, flushes, PC select and statistics out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       id_rs;
   logic [3:0]       id_rt;
   logic             id_uses_rt;
   logic             id_jump;
   logic             ex_memread;
   logic [3:0]       ex_rd;
   logic             ex_branch;
   logic             ex_zero;
   logic             ex_jr;
   logic             mem_access;
   logic             dmem_ready;
   logic             clr_stats;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic [1:0]       pc_sel;
   logic             state;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;
   logic             mem_timeout;

   // Pipeline side: supplies decoded flags, consumes the controls.
   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
             ex_branch, ex_zero, ex_jr, mem_access, dmem_ready, clr_stats,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, pc_sel, state, stall_cycles, flush_events, mem_timeout
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
             ex_branch, ex_zero, ex_jr, mem_access, dmem_ready, clr_stats,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, pc_sel, state, stall_cycles, flush_events, mem_timeout
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: priority-resolved
// stalls, freezes and redirects, a RUN/WAIT memory FSM with watchdog, and
// saturating stall/flush statistics.
module hazard_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

   localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   state_t           state_q, state_d;
   logic [WC_W-1:0]  wait_cnt;
   logic             mem_timeout_q;
   logic [CNT_W-1:0] stall_q, flush_q;

   logic p1_raw, p2_raw, lu_raw;
   logic case_p1, case_p2, case_p3, case_p4;
   logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
   logic ifid_flush_c, idex_flush_c;
   logic [1:0] pc_sel_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   assign p1_raw = bus.mem_access & ~bus.dmem_ready;
   assign p2_raw = (bus.ex_branch & bus.ex_zero) | bus.ex_jr;
   // r0 is hardwired zero, so a load "to r0" never produces a hazard.
   assign lu_raw = bus.ex_memread & (bus.ex_rd != 4'd0) &
                   ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));

   // Only the highest-priority condition is active in any cycle.
   assign case_p1 = p1_raw;
   assign case_p2 = ~p1_raw & p2_raw;
   assign case_p3 = ~p1_raw & ~p2_raw & lu_raw;
   assign case_p4 = ~p1_raw & ~p2_raw & ~lu_raw & bus.id_jump;

   // Next-state and combinational pipeline controls, forced idle in reset.
   always_comb begin
      pc_en_c      = 1'b1;
      ifid_en_c    = 1'b1;
      idex_en_c    = 1'b1;
      exmem_en_c   = 1'b1;
      memwb_en_c   = 1'b1;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      pc_sel_c     = 2'b00;
      state_d      = ST_RUN;
      if (case_p1) begin
         pc_en_c    = 1'b0;
         ifid_en_c  = 1'b0;
         idex_en_c  = 1'b0;
         exmem_en_c = 1'b0;
         memwb_en_c = 1'b0;
         state_d    = ST_WAIT;
      end else if (case_p2) begin
         pc_sel_c     = bus.ex_jr ? 2'b11 : 2'b10;
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
      end else if (case_p3) begin
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         idex_flush_c = 1'b1;
      end else if (case_p4) begin
         pc_sel_c     = 2'b01;
         ifid_flush_c = 1'b1;
      end
      if (!rst_n) begin
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         idex_en_c    = 1'b0;
         exmem_en_c   = 1'b0;
         memwb_en_c   = 1'b0;
         ifid_flush_c = 1'b0;
         idex_flush_c = 1'b0;
         pc_sel_c     = 2'b00;
      end
   end

   // RUN/WAIT state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // Watchdog: counts consecutive freeze cycles; timeout is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt      <= '0;
         mem_timeout_q <= 1'b0;
      end else if (case_p1) begin
         if (wait_cnt != WC_W'(WAIT_MAX)) wait_cnt <= wait_cnt + WC_W'(1);
         if ((int'(wait_cnt) + 1) >= WAIT_MAX) mem_timeout_q <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Saturating statistics; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else if (bus.clr_stats) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= sat_inc(stall_q, case_p1 | case_p3);
         flush_q <= sat_inc(flush_q, case_p2 | case_p4);
      end
   end

   assign bus.pc_en        = pc_en_c;
   assign bus.ifid_en      = ifid_en_c;
   assign bus.idex_en      = idex_en_c;
   assign bus.exmem_en     = exmem_en_c;
   assign bus.memwb_en     = memwb_en_c;
   assign bus.ifid_flush   = ifid_flush_c;
   assign bus.idex_flush   = idex_flush_c;
   assign bus.pc_sel       = pc_sel_c;
   assign bus.state        = state_q;
   assign bus.stall_cycles = stall_q;
   assign bus.flush_events = flush_q;
   assign bus.mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// against a rule-level reference model.
module tb_hazard_ctrl;
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 16;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;
   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel}
   wire [8:0] ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                     bus.ifid_flush, bus.idex_flush, bus.pc_sel};

   localparam logic [8:0] C_FREEZE = 9'b00000_00_00;
   localparam logic [8:0] C_RUN    = 9'b11111_00_00;
   localparam logic [8:0] C_LU     = 9'b00111_01_00;
   localparam logic [8:0] C_BR     = 9'b11111_11_10;
   localparam logic [8:0] C_JR     = 9'b11111_11_11;
   localparam logic [8:0] C_JMP    = 9'b11111_10_01;

   int vectors = 0;
   int errors  = 0;

   int m_stall, m_flush, m_wait;
   bit m_to, m_state;

   function automatic bit is_load_use();
      return bus.ex_memread && (bus.ex_rd != 0) &&
             ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
   endfunction

   function automatic logic [8:0] exp_ctl();
      if (!rst_n) return C_FREEZE;
      if (bus.mem_access && !bus.dmem_ready) return C_FREEZE;
      if (bus.ex_jr) return C_JR;
      if (bus.ex_branch && bus.ex_zero) return C_BR;
      if (is_load_use()) return C_LU;
      if (bus.id_jump) return C_JMP;
      return C_RUN;
   endfunction

   task automatic model_reset();
      m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0; m_state = 0;
   endtask

   task automatic model_update();
      bit p1, p2, lu;
      if (!rst_n) begin
         model_reset();
         return;
      end
      p1 = bus.mem_access && !bus.dmem_ready;
      p2 = bus.ex_jr || (bus.ex_branch && bus.ex_zero);
      lu = is_load_use();
      if (bus.clr_stats) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if ((p1 || (!p2 && lu)) && m_stall < CMAX) m_stall++;
         if (!p1 && (p2 || (!lu && bus.id_jump)) && m_flush < CMAX) m_flush++;
      end
      if (p1) begin
         m_wait++;
         if (m_wait >= WAIT_MAX) m_to = 1;
         m_state = 1;
      end else begin
         m_wait  = 0;
         m_state = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_jump = 0;
      bus.ex_memread = 0; bus.ex_rd = 0; bus.ex_branch = 0; bus.ex_zero = 0;
      bus.ex_jr = 0; bus.mem_access = 0; bus.dmem_ready = 1; bus.clr_stats = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.id_rs = 4'd3; bus.id_rt = 4'd3; bus.id_uses_rt = 1; bus.id_jump = 1;
      bus.ex_memread = 1; bus.ex_rd = 4'd3; bus.ex_branch = 1; bus.ex_zero = 1;
      bus.ex_jr = 0; bus.mem_access = 0; bus.dmem_ready = 1; bus.clr_stats = 0;
      model_reset();
      #2;
      vectors++;
      if (ctl !== C_FREEZE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_FREEZE); end
      tick();
      vectors++;
      if ({bus.state, bus.mem_timeout, bus.stall_cycles, bus.flush_events} !== {1'b0, 1'b0, 16'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_regs: got state=%b to=%b stall=%0d flush=%0d expected all zero",
                  bus.state, bus.mem_timeout, bus.stall_cycles, bus.flush_events);
      end
      rst_n = 1'b1;
      set_idle();
      #1;
   endtask

   task automatic test_load_use();
      set_idle();
      bus.ex_memread = 1; bus.ex_rd = 4'd3; bus.id_rs = 4'd3;
      #2;
      vectors++;
      if (ctl !== C_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctl, C_LU); end
      tick();
      set_idle();
      bus.mem_access = 1; bus.dmem_ready = 1;
      #2;
      vectors++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL lu_release: got %b expected %b", ctl, C_RUN); end
      vectors++;
      if (bus.stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", bus.stall_cycles); end
      tick();
      // rt-side hazard only counts when the instruction really reads rt
      set_idle();
      bus.ex_memread = 1; bus.ex_rd = 4'd7; bus.id_rt = 4'd7; bus.id_uses_rt = 1;
      #2;
      vectors++;
      if (ctl !== C_LU) begin errors++; $display("FAIL lu_rt: got %b expected %b", ctl, C_LU); end
      bus.id_uses_rt = 0;
      #1;
      vectors++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL lu_rt_unused: got %b expected %b", ctl, C_RUN); end
      tick();
   endtask

   task automatic test_reg0();
      set_idle();
      bus.ex_memread = 1; bus.ex_rd = 4'd0; bus.id_rs = 4'd0; bus.id_rt = 4'd0; bus.id_uses_rt = 1;
      #2;
      vectors++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL reg0_nostall: got %b expected %b", ctl, C_RUN); end
      tick();
   endtask

   task automatic test_redirect();
      int f0;
      set_idle();
      f0 = m_flush;
      bus.ex_branch = 1; bus.ex_zero = 1; bus.id_jump = 1;
      bus.ex_memread = 1; bus.ex_rd = 4'd4; bus.id_rs = 4'd4;
      #2;
      vectors++;
      if (ctl !== C_BR) begin errors++; $display("FAIL br_priority: got %b expected %b", ctl, C_BR); end
      tick();
      vectors++;
      if (bus.flush_events !== 16'(f0 + 1)) begin
         errors++; $display("FAIL br_flushcnt: got %0d expected %0d", bus.flush_events, f0 + 1);
      end
      set_idle();
      bus.ex_jr = 1; bus.ex_branch = 1; bus.ex_zero = 1;
      #2;
      vectors++;
      if (ctl !== C_JR) begin errors++; $display("FAIL jr_wins: got %b expected %b", ctl, C_JR); end
      tick();
      set_idle();
      bus.ex_branch = 1; bus.ex_zero = 0; bus.id_jump = 1;
      #2;
      vectors++;
      if (ctl !== C_JMP) begin errors++; $display("FAIL id_jump: got %b expected %b", ctl, C_JMP); end
      tick();
      vectors++;
      if (bus.flush_events !== 16'(f0 + 3)) begin
         errors++; $display("FAIL redirect_flushcnt: got %0d expected %0d", bus.flush_events, f0 + 3);
      end
      set_idle();
      bus.ex_jr = 1; bus.mem_access = 1; bus.dmem_ready = 0;
      #2;
      vectors++;
      if (ctl !== C_FREEZE) begin errors++; $display("FAIL wait_over_jr: got %b expected %b", ctl, C_FREEZE); end
      tick();
      set_idle();
      tick();
   endtask

   task automatic test_mem_wait();
      set_idle();
      bus.clr_stats = 1;
      tick();
      set_idle();
      bus.mem_access = 1; bus.dmem_ready = 0;
      bus.ex_memread = 1; bus.ex_rd = 4'd5; bus.id_rs = 4'd5;
      for (int k = 0; k < 20; k++) begin
         #2;
         vectors++;
         if ({ctl, bus.state, bus.mem_timeout} !== {C_FREEZE, (k != 0), (k >= 15)}) begin
            errors++;
            $display("FAIL wait_cycle%0d: got ctl=%b state=%b to=%b expected ctl=%b state=%b to=%b",
                     k, ctl, bus.state, bus.mem_timeout, C_FREEZE, (k != 0), (k >= 15));
         end
         tick();
      end
      bus.dmem_ready = 1;
      #2;
      vectors++;
      if ({ctl, bus.state, bus.mem_timeout, bus.stall_cycles} !== {C_LU, 1'b1, 1'b1, 16'd20}) begin
         errors++;
         $display("FAIL wait_exit: got ctl=%b state=%b to=%b stall=%0d expected ctl=%b state=1 to=1 stall=20",
                  ctl, bus.state, bus.mem_timeout, bus.stall_cycles, C_LU);
      end
      tick();
      set_idle();
      #2;
      vectors++;
      if ({bus.state, bus.mem_timeout, bus.stall_cycles} !== {1'b0, 1'b1, 16'd21}) begin
         errors++;
         $display("FAIL wait_after: got state=%b to=%b stall=%0d expected state=0 to=1 stall=21",
                  bus.state, bus.mem_timeout, bus.stall_cycles);
      end
      tick();
   endtask

   task automatic test_saturation();
      set_idle();
      bus.ex_memread = 1; bus.ex_rd = 4'd9; bus.id_rs = 4'd9;
      for (int i = 0; i < 70000; i++) tick();
      #2;
      vectors++;
      if (bus.stall_cycles !== 16'hFFFF || m_stall != CMAX) begin
         errors++; $display("FAIL stall_saturate: got %h expected ffff", bus.stall_cycles);
      end
      bus.clr_stats = 1;
      tick();
      bus.clr_stats = 0;
      #2;
      vectors++;
      if ({bus.stall_cycles, bus.flush_events, bus.mem_timeout} !== {16'd0, 16'd0, 1'b1}) begin
         errors++;
         $display("FAIL clr_stats: got stall=%0d flush=%0d to=%b expected stall=0 flush=0 to=1",
                  bus.stall_cycles, bus.flush_events, bus.mem_timeout);
      end
      tick();
      set_idle();
      tick();
   endtask

   task automatic test_reset_mid_wait();
      set_idle();
      bus.mem_access = 1; bus.dmem_ready = 0;
      repeat (3) tick();
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({ctl, bus.state, bus.stall_cycles, bus.flush_events, bus.mem_timeout} !==
          {C_FREEZE, 1'b0, 16'd0, 16'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got ctl=%b state=%b stall=%0d flush=%0d to=%b expected all zero",
                  ctl, bus.state, bus.stall_cycles, bus.flush_events, bus.mem_timeout);
      end
      model_reset();
      rst_n = 1'b1;
      set_idle();
      #1;
      tick();
   endtask

   task automatic test_random();
      logic [41:0] got, exp;
      for (int n = 0; n < 400; n++) begin
         bus.id_rs      = 4'($urandom_range(0, 3));
         bus.id_rt      = 4'($urandom_range(0, 3));
         bus.id_uses_rt = ($urandom_range(0, 1) == 1);
         bus.id_jump    = ($urandom_range(0, 4) == 0);
         bus.ex_memread = ($urandom_range(0, 2) == 0);
         bus.ex_rd      = 4'($urandom_range(0, 3));
         bus.ex_branch  = ($urandom_range(0, 4) == 0);
         bus.ex_zero    = ($urandom_range(0, 1) == 1);
         bus.ex_jr      = ($urandom_range(0, 9) == 0);
         bus.mem_access = ($urandom_range(0, 2) == 0);
         bus.dmem_ready = ($urandom_range(0, 9) < 6);
         bus.clr_stats  = ($urandom_range(0, 19) == 0);
         #2;
         got = {ctl, bus.state, bus.mem_timeout, bus.stall_cycles, bus.flush_events};
         exp = {exp_ctl(), m_state, m_to, 16'(m_stall), 16'(m_flush)};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random%0d: got %h expected %h", n, got, exp);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_reg0();
      test_redirect();
      test_mem_wait();
      test_saturation();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
